// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table and segment bit positions.
package seg_pkg;

  // Bit positions within an 8-bit segment byte (a is the MSB, dp the LSB).
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Active-high a..g,dp glyphs; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] HEX_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-high a..g segment decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = HEX_TABLE[nibble];
    seg   = glyph[SEG_A:SEG_G];
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with shadow registers, de-ghost blanking
// and optional leading-zero suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned BLANK   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [7:0]            seg_n_q, seg_n_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;

  logic [3:0]            nib_sel;
  logic [6:0]            seg_hi;
  logic [DIGITS-1:0]     lz;
  logic                  suppress;

  // lz[i]: nibbles i..DIGITS-1 of the shadow are all zero.
  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lz[i] = 1'b1;
      for (int unsigned j = i; j < DIGITS; j++) begin
        if (data_q[4*j +: 4] != 4'h0) lz[i] = 1'b0;
      end
    end
  end

  always_comb begin
    nib_sel  = data_q[{idx_q, 2'b00} +: 4];
    suppress = blank_lz && (idx_q != '0) && lz[idx_q];
  end

  seg_hex_dec u_dec (
    .nibble (nib_sel),
    .seg    (seg_hi)
  );

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_n_d = SEG_ALL_OFF;
    an_n_d  = '1;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q >= BlankEnd) begin
        an_n_d[idx_q] = 1'b0;
        seg_n_d       = ~{(suppress ? 7'h00 : seg_hi), dp_q[idx_q]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      seg_n_q <= SEG_ALL_OFF;
      an_n_q  <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
      if (load) begin
        data_q <= data_in;
        dp_q   <= dp_in;
      end
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed plus randomised bench for seg_scan: a cycle model feeds a scoreboard queue,
// and spot checks pin the documented display values.
module tb_seg_scan;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;

  localparam logic [7:0] HEX [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  int          m_cnt, m_idx, m_oidx, m_ocnt;
  logic        m_lit;
  logic [15:0] m_data;
  logic [3:0]  m_dp;

  seg_scan #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .enable   (enable),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  // Predict the outputs the coming edge will register and advance the model.
  task automatic model_step();
    exp_t       e;
    logic [7:0] act;
    e.seg = 8'hFF;
    e.an  = 4'hF;
    m_lit = 1'b0;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_data = '0; m_dp = '0;
    end else begin
      if (enable) begin
        m_oidx = m_idx;
        m_ocnt = m_cnt;
        if (m_cnt >= BLANK) begin
          m_lit = 1'b1;
          e.an  = ~(4'b0001 << m_idx);
          act   = HEX[m_data[4*m_idx +: 4]];
          if (blank_lz && m_idx != 0 && (m_data >> (4*m_idx)) == 16'h0) act = 8'h00;
          if (m_dp[m_idx]) act[0] = 1'b1;
          e.seg = ~act;
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == CLK_DIV) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % DIGITS;
        end
      end else begin
        m_cnt = 0;
        m_idx = 0;
      end
      if (load) begin
        m_data = data_in;
        m_dp   = dp_in;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_empty: scoreboard queue empty, required one entry");
    end else begin
      e = sb_q.pop_front();
      assert ({seg_n, an_n} === {e.seg, e.an}) n_pass++;
      else $error("FAIL sb: seg_n=%h an_n=%b, expected seg_n=%h an_n=%b",
                  seg_n, an_n, e.seg, e.an);
    end
  endtask

  task automatic spot(input string tag, input logic [7:0] s, input logic [3:0] a);
    n_checks++;
    assert (seg_n === s && an_n === a) n_pass++;
    else $error("FAIL %s: seg_n=%h an_n=%b, expected seg_n=%h an_n=%b",
                tag, seg_n, an_n, s, a);
  endtask

  // Tick until the last registered output is the first lit cycle of digit d.
  task automatic goto_slot(input int d);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!(m_lit && m_oidx == d && m_ocnt == BLANK) && k < 40);
    if (k >= 40) begin
      n_checks++;
      $error("FAIL goto_slot: digit %0d not reached within 40 cycles, required reach", d);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0;
    data_in = '0; dp_in = '0;
    m_cnt = 0; m_idx = 0; m_oidx = 0; m_ocnt = 0; m_lit = 1'b0; m_data = '0; m_dp = '0;

    // Reset and first frame
    repeat (3) begin
      tick();
      spot("reset", 8'hFF, 4'b1111);
    end
    rst = 1'b0;
    tick();
    spot("post_reset_blank", 8'hFF, 4'b1111);
    tick();
    spot("post_reset_d0", 8'h03, 4'b1110);

    // Basic hex display and frame length
    do_load(16'h1234, 4'b0000);
    goto_slot(0);
    spot("d0_1234", 8'h99, 4'b1110);
    goto_slot(3);
    spot("d3_1234", 8'h9F, 4'b0111);
    repeat (16) tick();
    spot("frame_16", 8'h9F, 4'b0111);

    // Leading-zero suppression
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    goto_slot(3);
    spot("lz_d3", 8'hFF, 4'b0111);
    goto_slot(2);
    spot("lz_d2", 8'hFF, 4'b1011);
    goto_slot(1);
    spot("lz_d1", 8'h49, 4'b1101);
    goto_slot(0);
    spot("lz_d0", 8'h03, 4'b1110);
    do_load(16'h0000, 4'b0000);
    goto_slot(0);
    spot("lz_zero_d0", 8'h03, 4'b1110);
    goto_slot(1);
    spot("lz_zero_d1", 8'hFF, 4'b1101);

    // Decimal points
    blank_lz = 1'b0;
    do_load(16'h0008, 4'b0001);
    goto_slot(0);
    spot("dp_d0", 8'h00, 4'b1110);
    blank_lz = 1'b1;
    do_load(16'h0008, 4'b0100);
    goto_slot(2);
    spot("dp_suppressed_d2", 8'hFE, 4'b1011);

    // Load timing on a digit-0 output cycle
    blank_lz = 1'b0;
    do_load(16'h0008, 4'b0000);
    goto_slot(0);
    do_load(16'h0001, 4'b0000);
    spot("load_old", 8'h01, 4'b1110);
    tick();
    spot("load_new", 8'h9F, 4'b1110);

    // Enable dropped mid-slot, then resumed
    goto_slot(1);
    enable = 1'b0;
    tick();
    spot("disable_1", 8'hFF, 4'b1111);
    tick();
    spot("disable_2", 8'hFF, 4'b1111);
    enable = 1'b1;
    tick();
    spot("reenable_blank", 8'hFF, 4'b1111);
    tick();
    spot("reenable_d0", 8'h9F, 4'b1110);

    // Reset overrides load mid-scan
    goto_slot(2);
    rst = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF; load = 1'b1;
    tick();
    spot("rst_load", 8'hFF, 4'b1111);
    rst = 1'b0; load = 1'b0;
    tick();
    spot("rst_restart_blank", 8'hFF, 4'b1111);
    tick();
    spot("rst_restart_d0", 8'h03, 4'b1110);

    // Shadow stays put while data_in wanders
    repeat (20) begin
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      tick();
    end

    // Randomised traffic against the model
    repeat (400) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 5) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      blank_lz = 1'($urandom);
      rst      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) data_in = 16'($urandom_range(0, 255));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, 8, number of multiplexed digits (1..16).
REQ-002 SHALL have parameter CLK_DIV, 50000, clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLANK, 2, leading all-off cycles per slot, de-ghosting (0..CLK_DIV-1).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  4*DIGITS  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-007 SHALL have port dp_in  input  DIGITS  decimal-point request per digit.
REQ-008 SHALL have port load  input  1  strobe; captures data_in/dp_in into shadow registers.
REQ-009 SHALL have port blank_lz  input  1  leading-zero suppression enable.
REQ-010 SHALL have port enable  input  1  scan enable; low = display dark.
REQ-011 SHALL have port seg_n  output  8  active-low segments: bit7=a .. bit1=g, bit0=dp.
REQ-012 SHALL have port an_n  output  DIGITS  active-low one-cold digit select.

Function
REQ-013 SHALL hold a slot counter cnt (0..CLK_DIV-1) and digit index idx (0..DIGITS-1).
REQ-014 When enable=1, cnt SHALL increment each cycle; at CLK_DIV-1 it wraps to 0 and idx advances, wrapping DIGITS-1 -> 0.
REQ-015 When enable=0, cnt and idx SHALL be forced to 0, seg_n to 8'hFF and an_n to all ones, from the next edge on.
REQ-016 seg_n and an_n SHALL be registered: values after edge t are computed from cnt, idx and shadow before edge t.
REQ-017 If cnt<BLANK, outputs SHALL be seg_n=8'hFF, an_n=all ones; otherwise an_n bit idx SHALL be 0, all other bits 1.
REQ-018 Active-high hex table: 0 FC,1 60,2 DA,3 F2,4 66,5 B6,6 BE,7 E0,8 FE,9 F6,A EE,b 3E,C 9C,d 7A,E 9E,F 8E; seg_n SHALL be its bitwise inverse, with bit0 cleared when the digit's shadow dp bit is 1.
REQ-019 With blank_lz=1, digit i>0 SHALL show segments a-g off if shadow nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed; dp is unaffected by suppression.
REQ-020 load=1 at edge t SHALL update the shadow at edge t; outputs computed at edge t SHALL still use the old shadow; new values appear from edge t+1.
REQ-021 load SHALL NOT disturb cnt or idx; back-to-back loads SHALL keep only the last.
REQ-022 The shadow SHALL remain static between loads regardless of data_in changes.

Reset
REQ-023 On rst=1 at an edge: cnt=0, idx=0, shadow data=0, shadow dp=0, seg_n=8'hFF, an_n=all ones.
REQ-024 rst SHALL override load and enable in the same cycle; mid-scan reset SHALL restart from digit 0, cnt 0.

Structure
REQ-025 Package seg_pkg SHALL hold the 16-entry hex segment table and segment bit-position constants.
REQ-026 One combinational sub-module, seg_hex_dec (nibble -> active-high a..g), SHALL be instantiated once on the selected digit.
REQ-027 No other sub-modules; the counter, mux and suppression logic live in seg_scan.

Verification (DIGITS=4, CLK_DIV=4, BLANK=1)
REQ-028 Reset held 3 cycles, then released with enable=1 -> seg_n=8'hFF, an_n=4'b1111 during reset and the first cycle after; next cycle an_n=4'b1110, seg_n=8'h03.
REQ-029 load with data_in=16'h1234, dp_in=0 -> digit-0 slot shows seg_n=8'h99, an_n=4'b1110; digit-3 slot shows 8'h9F, an_n=4'b0111; one full frame=16 cycles.
REQ-030 data_in=16'h0050, blank_lz=1 -> digits 3,2 seg_n=8'hFF with anode asserted, digit 1 8'h49, digit 0 8'h03; data_in=0 -> digit 0 8'h03, others 8'hFF.
REQ-031 data_in=16'h0008, dp_in=4'b0001 -> digit-0 slot seg_n=8'h00; dp_in=4'b0100 with blank_lz=1 -> digit 2 seg_n=8'hFE.
REQ-032 load asserted on a digit-0 output cycle -> that cycle's output uses old value, next cycle new value; enable dropped mid-slot -> next cycle all-off; re-enable -> scan resumes at digit 0 after BLANK cycle.
REQ-033 rst pulsed with load=1 during digit-2 slot -> shadow=0, outputs all-off next cycle, scan restarts at digit 0.
